sram_bitline_ctrl: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 27 ++
 rtl/sram_bitline_ctrl_col_io.sv | 62 ++++++
 rtl/sram_bitline_ctrl.sv | 138 +++++++++++++
 tb/tb_sram_bitline_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared state encodings, bitline drive modes and the per-column sense decode
// for the SRAM bitline controller.
package sram_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRE     = 3'd1;
    localparam logic [2:0] ST_ISO     = 3'd2;
    localparam logic [2:0] ST_ACCESS  = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [1:0] {
        DRV_REL   = 2'd0,
        DRV_PRECH = 2'd1,
        DRV_WRITE = 2'd2
    } drv_mode_e;

    // Returns {err, bit}: only a clean differential pair is a valid read.
    function automatic logic [1:0] sense_encode(input logic b, input logic bb);
        case ({b, bb})
            2'b10:   sense_encode = 2'b01;
            2'b01:   sense_encode = 2'b00;
            default: sense_encode = 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/sram_bitline_ctrl_col_io.sv
// Column I/O: tristate precharge/write drivers on bl/blb and the 4-state
// sense comparator with its capture register.
module sram_col_io
    import sram_ctrl_pkg::*;
#(
    parameter int COLS = 8
) (
    input  logic            clk,
    input  drv_mode_e       mode,
    input  logic [COLS-1:0] wdata,
    input  logic            capture,
    output logic [COLS-1:0] sense_data,
    output logic            sense_err,
    inout  wire  [COLS-1:0] bl,
    inout  wire  [COLS-1:0] blb
);

    logic            drv_en;
    logic [COLS-1:0] drv_bl;
    logic [COLS-1:0] drv_blb;
    logic [COLS-1:0] sense_bit;
    logic [COLS-1:0] sense_bad;

    always_comb begin
        drv_en  = 1'b0;
        drv_bl  = '0;
        drv_blb = '0;
        case (mode)
            DRV_PRECH: begin
                drv_en  = 1'b1;
                drv_bl  = '1;
                drv_blb = '1;
            end
            DRV_WRITE: begin
                drv_en  = 1'b1;
                drv_bl  = wdata;
                drv_blb = ~wdata;
            end
            default: ;
        endcase
    end

    assign bl  = drv_en ? drv_bl  : {COLS{1'bz}};
    assign blb = drv_en ? drv_blb : {COLS{1'bz}};

    always_comb begin
        sense_bit = '0;
        sense_bad = '0;
        for (int i = 0; i < COLS; i++) begin
            {sense_bad[i], sense_bit[i]} = sense_encode(bl[i], blb[i]);
        end
    end

    // Sense capture: sampled while the wordline is still high.
    always_ff @(posedge clk) begin
        if (capture) begin
            sense_data <= sense_bit;
            sense_err  <= |sense_bad;
        end
    end

endmodule

// File: rtl/sram_bitline_ctrl.sv
// Bitline/wordline sequencer for a ROWS x COLS weak-driver SRAM array:
// precharge, isolate, wordline pulse, recover, respond.
module sram_bitline_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 8,
    parameter int ADDR_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int PRE_CYC = 1,
    parameter int WL_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [COLS-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [COLS-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [ROWS-1:0]   wl,
    inout  wire  [COLS-1:0]   bl,
    inout  wire  [COLS-1:0]   blb
);

    logic [2:0]        state;
    logic [7:0]        cnt;
    logic              we_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [COLS-1:0]   wdata_p0;
    logic              accept;
    logic              in_range;
    logic              capture;
    drv_mode_e         mode;
    logic [COLS-1:0]   sense_data;
    logic              sense_err;

    generate
        if ((1 << ADDR_W) > ROWS) begin : g_range_chk
            assign in_range = (req_addr < ADDR_W'(ROWS));
        end else begin : g_range_full
            assign in_range = 1'b1;
        end
    endgenerate

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == ST_DONE);
    assign capture   = (state == ST_ACCESS) && (cnt == 8'(WL_CYC - 1)) && !we_p0;

    // PRE count 0 is the row-decode cycle; precharge drives on counts 1..PRE_CYC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= in_range ? ST_PRE : ST_DONE;
                        cnt   <= '0;
                    end
                end
                ST_PRE: begin
                    if (cnt == 8'(PRE_CYC)) begin
                        state <= ST_ISO;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_ISO: state <= ST_ACCESS;
                ST_ACCESS: begin
                    if (cnt == 8'(WL_CYC - 1)) begin
                        state <= ST_RECOVER;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RECOVER: state <= ST_DONE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Request stage: captured on the handshake edge, held for the whole access.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept && !in_range) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end else if (state == ST_RECOVER) begin
            rsp_rdata <= we_p0 ? '0 : sense_data;
            rsp_err   <= we_p0 ? 1'b0 : sense_err;
        end
    end

    // Write drivers span ISO..RECOVER so wl is low on both sides of the drive window.
    always_comb begin
        mode = DRV_REL;
        case (state)
            ST_PRE:                        if (cnt != 8'd0) mode = DRV_PRECH;
            ST_ISO, ST_ACCESS, ST_RECOVER: if (we_p0) mode = DRV_WRITE;
            default: ;
        endcase
    end

    always_comb begin
        wl = '0;
        for (int r = 0; r < ROWS; r++) begin
            wl[r] = (state == ST_ACCESS) && (addr_p0 == ADDR_W'(r));
        end
    end

    sram_col_io #(.COLS(COLS)) u_col_io (
        .clk        (clk),
        .mode       (mode),
        .wdata      (wdata_p0),
        .capture    (capture),
        .sense_data (sense_data),
        .sense_err  (sense_err),
        .bl         (bl),
        .blb        (blb)
    );

endmodule

// File: tb/tb_sram_bitline_ctrl.sv
// Bench for sram_bitline_ctrl: behavioural bitcell array on the bitlines,
// response scoreboard, per-cycle wordline/precharge overlap monitor.
module tb_sram_bitline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_we;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic [3:0] wl;
    wire  [7:0] bl, blb;

    logic       req_valid3;
    logic [1:0] req_addr3;
    logic       req_ready3, rsp_valid3, rsp_err3;
    logic [7:0] rsp_rdata3;
    logic [2:0] wl3;
    wire  [7:0] bl3, blb3;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [7:0] model_mem [4];
    logic [3:0] model_init = 4'b0;
    logic [7:0] cell_mem [4];
    logic [3:0] cell_init = 4'b0;
    logic       cur_we    = 1'b0;
    logic       probe_oe  = 1'b0;
    logic       tb_oe;
    logic [7:0] tb_bl, tb_blb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_bitline_ctrl #(.ROWS(4), .COLS(8), .PRE_CYC(1), .WL_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wl(wl), .bl(bl), .blb(blb)
    );

    sram_bitline_ctrl #(.ROWS(3), .COLS(8), .PRE_CYC(1), .WL_CYC(2)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(req_we), .req_addr(req_addr3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .wl(wl3), .bl(bl3), .blb(blb3)
    );

    // Bitcells: latch the bitlines while selected during a write, drive them
    // (complementary) while selected during a read; never-written cells stay silent.
    always_comb begin
        tb_oe  = probe_oe;
        tb_bl  = 8'h00;
        tb_blb = 8'h00;
        for (int r = 0; r < 4; r++) begin
            if (wl[r] && cell_init[r] && !cur_we) begin
                tb_oe  = 1'b1;
                tb_bl  = cell_mem[r];
                tb_blb = ~cell_mem[r];
            end
        end
    end

    assign bl  = tb_oe ? tb_bl  : 8'bz;
    assign blb = tb_oe ? tb_blb : 8'bz;

    always @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            if (wl[r] && cur_we) begin
                cell_mem[r]  <= bl;
                cell_init[r] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (wl !== 4'b0000) begin
            tests++;
            if ((|(bl & blb)) === 1'b1) begin
                fails++;
                $display("FAIL wl_overlap: wl=%b with bl=%h blb=%h, required no column at 1/1", wl, bl, blb);
            end
        end
        if (rsp_valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL rsp_spurious: rsp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err || cyc != mon_e.due) begin
                    fails++;
                    $display("FAIL rsp: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                             rsp_rdata, rsp_err, cyc, mon_e.rdata, mon_e.err, mon_e.due);
                end
            end
        end
    end

    // Drives one request from a negedge, checks the access timeline, returns at the DONE negedge.
    task automatic do_op(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                         input bit hold, output int t_acc, output logic [3:0] seen);
        int         guard;
        exp_t       ex;
        logic [3:0] exp_wl;
        seen      = 4'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        guard     = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (guard >= 20) begin
            fails++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, guard);
            t_acc     = cyc;
            req_valid = 1'b0;
            return;
        end
        t_acc  = cyc;
        cur_we = we;
        if (we) begin
            ex.rdata = 8'h00;
            ex.err   = 1'b0;
            model_mem[addr]  = wd;
            model_init[addr] = 1'b1;
        end else if (model_init[addr]) begin
            ex.rdata = model_mem[addr];
            ex.err   = 1'b0;
        end else begin
            ex.rdata = 8'h00;
            ex.err   = 1'b1;
        end
        ex.due = t_acc + 7;
        sb.push_back(ex);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) req_valid = 1'b0;
            exp_wl = (k == 4 || k == 5) ? (4'b0001 << addr) : 4'b0000;
            seen   = seen | wl;
            tests += 2;
            if (wl !== exp_wl) begin
                fails++;
                $display("FAIL wl_pattern: T+%0d wl=%b, required %b", k, wl, exp_wl);
            end
            if (req_ready !== 1'b0) begin
                fails++;
                $display("FAIL ready_busy: T+%0d req_ready=%b, required 0", k, req_ready);
            end
            if (k == 2) begin
                tests++;
                if (bl !== 8'hFF || blb !== 8'hFF) begin
                    fails++;
                    $display("FAIL precharge: bl=%h blb=%h, required ff/ff", bl, blb);
                end
            end
            if (k == 6 && we) begin
                tests++;
                if (bl !== wd || blb !== ~wd) begin
                    fails++;
                    $display("FAIL recover_hold: bl=%h blb=%h, required %h/%h", bl, blb, wd, ~wd);
                end
            end
            if (k == 6) probe_oe = 1'b1;
            if (k == 7) begin
                tests++;
                if (bl !== 8'h00 || blb !== 8'h00) begin
                    fails++;
                    $display("FAIL release_done: probed bl=%h blb=%h, required 00/00", bl, blb);
                end
                probe_oe = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; req_we = 1'b0;
        req_addr = 2'd0; req_addr3 = 2'd0; req_wdata = 8'h00;
        probe_oe = 1'b1;
        repeat (3) @(negedge clk);
        tests += 6;
        if (wl !== 4'b0) begin fails++; $display("FAIL reset_wl: wl=%b, required 0000", wl); end
        if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: req_ready=%b, required 0", req_ready); end
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: %b, required 0", rsp_valid); end
        if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata: %h, required 00", rsp_rdata); end
        if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_err: %b, required 0", rsp_err); end
        if (bl !== 8'h00 || blb !== 8'h00) begin
            fails++; $display("FAIL reset_release: probed bl=%h blb=%h, required 00/00", bl, blb);
        end
        probe_oe = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests += 2;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: req_ready=%b, required 1", req_ready); end
        if (req_ready3 !== 1'b1) begin fails++; $display("FAIL idle_ready3: req_ready=%b, required 1", req_ready3); end
    endtask

    task automatic test_write_read();
        int t;
        logic [3:0] s;
        do_op(1'b1, 2'd2, 8'hA5, 1'b0, t, s);
        do_op(1'b0, 2'd2, 8'h00, 1'b0, t, s);
        tests++;
        if (s !== 4'b0100) begin fails++; $display("FAIL row2_seen: wl seen=%b, required 0100", s); end
        repeat (2) @(negedge clk);
        tests += 2;
        if (rsp_rdata !== 8'hA5) begin fails++; $display("FAIL rdata_hold: rsp_rdata=%h, required a5", rsp_rdata); end
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rsp_pulse: rsp_valid=%b, required 0", rsp_valid); end
    endtask

    task automatic test_rows_0_3();
        int t;
        logic [3:0] s, all;
        all = 4'b0;
        do_op(1'b1, 2'd0, 8'hFF, 1'b0, t, s); all |= s;
        do_op(1'b1, 2'd3, 8'h00, 1'b0, t, s); all |= s;
        do_op(1'b0, 2'd0, 8'h00, 1'b0, t, s); all |= s;
        do_op(1'b0, 2'd3, 8'h00, 1'b0, t, s); all |= s;
        tests++;
        if (all !== 4'b1001) begin fails++; $display("FAIL rows_seen: wl seen=%b, required 1001", all); end
    endtask

    task automatic test_uninit_back_to_back();
        int t1, t2;
        logic [3:0] s;
        do_op(1'b0, 2'd1, 8'h00, 1'b1, t1, s);
        do_op(1'b0, 2'd1, 8'h00, 1'b1, t2, s);
        req_valid = 1'b0;
        tests++;
        if (t2 - t1 != 8) begin fails++; $display("FAIL b2b_interval: %0d cycles, required 8", t2 - t1); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int t;
        logic [3:0] s;
        for (int i = 0; i < 100; i++) begin
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 1'b0, t, s);
        end
        @(negedge clk);
    endtask

    task automatic test_oor_rows3();
        req_valid3 = 1'b1;
        req_addr3  = 2'd3;
        tests++;
        if (req_ready3 !== 1'b1) begin fails++; $display("FAIL oor_ready: req_ready=%b, required 1", req_ready3); end
        @(negedge clk);
        req_valid3 = 1'b0;
        tests += 4;
        if (rsp_valid3 !== 1'b1) begin fails++; $display("FAIL oor_valid: rsp_valid=%b at T+1, required 1", rsp_valid3); end
        if (rsp_err3 !== 1'b1) begin fails++; $display("FAIL oor_err: rsp_err=%b, required 1", rsp_err3); end
        if (rsp_rdata3 !== 8'h00) begin fails++; $display("FAIL oor_rdata: %h, required 00", rsp_rdata3); end
        if (wl3 !== 3'b000) begin fails++; $display("FAIL oor_wl: wl=%b, required 000", wl3); end
        @(negedge clk);
        tests += 3;
        if (rsp_valid3 !== 1'b0) begin fails++; $display("FAIL oor_pulse: rsp_valid=%b, required 0", rsp_valid3); end
        if (req_ready3 !== 1'b1) begin fails++; $display("FAIL oor_idle: req_ready=%b, required 1", req_ready3); end
        if (wl3 !== 3'b000) begin fails++; $display("FAIL oor_wl_after: wl=%b, required 000", wl3); end
    endtask

    task automatic test_reset_mid_write();
        int t;
        logic [3:0] s;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd1; req_wdata = 8'h3C;
        cur_we = 1'b1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: req_ready=%b, required 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (wl !== 4'b0010) begin fails++; $display("FAIL mid_access: wl=%b, required 0010", wl); end
        rst = 1'b1;
        @(negedge clk);
        tests += 2;
        if (wl !== 4'b0000) begin fails++; $display("FAIL mid_wl: wl=%b after reset edge, required 0000", wl); end
        if (req_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_rst: req_ready=%b, required 0", req_ready); end
        probe_oe = 1'b1;
        #1;
        tests++;
        if (bl !== 8'h00 || blb !== 8'h00) begin
            fails++; $display("FAIL mid_release: probed bl=%h blb=%h, required 00/00", bl, blb);
        end
        probe_oe = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_idle: req_ready=%b, required 1", req_ready); end
        // The cell latched 3C on the one ACCESS edge it saw before reset.
        model_mem[1]  = 8'h3C;
        model_init[1] = 1'b1;
        do_op(1'b0, 2'd1, 8'h00, 1'b0, t, s);
        do_op(1'b0, 2'd2, 8'h00, 1'b0, t, s);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rows_0_3();
        test_uninit_back_to_back();
        test_random();
        test_oor_rows3();
        test_reset_mid_write();
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL rsp_missing: %0d responses outstanding, required 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
